// File: rtl/sim_run_controller.sv
// Run controller for the single-cycle RV32 core: sequences core reset, counts RUN cycles and
// flags completion via TOHOST write or timeout. Define HANG_DETECT_EN to add stuck-PC detection.
module sim_run_controller #(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     CNT_W          = 32,
    parameter int unsigned     RESET_CYCLES   = 4,
    parameter int unsigned     TIMEOUT_CYCLES = 1000,
    parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'('h0000_0FF0),
    parameter int unsigned     HANG_CYCLES    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [XLEN-1:0]  pc,
    input  logic             dmem_we,
    input  logic [XLEN-1:0]  dmem_addr,
    input  logic [XLEN-1:0]  dmem_wdata,
    output logic             core_rst_n,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic             hang,
    output logic [XLEN-1:0]  fail_code,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StHold, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0] cycle_count_q, count_inc;
    logic [XLEN-1:0]  fail_code_q;
    logic             pass_q, timeout_q, hang_q;
    logic             in_run, start_ok, hold_last;
    logic             tohost_hit, timeout_hit, hang_hit;

    assign in_run    = (state_q == StRun);
    assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
    assign hold_last = (hold_q == HOLD_W'(RESET_CYCLES - 1));
    // Saturating increment; the value reached on this edge is what timeout compares against.
    assign count_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);

    assign tohost_hit  = in_run && dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_wdata != '0);
    assign timeout_hit = in_run && (count_inc == CNT_W'(TIMEOUT_CYCLES));

`ifdef HANG_DETECT_EN
    localparam int unsigned HANG_W = $clog2(HANG_CYCLES + 1);

    logic [XLEN-1:0]   last_pc_q;
    logic [HANG_W-1:0] hang_cnt_q, hang_cnt_d;

    // Count is 1 on the first cycle a PC value is seen, so HANG_CYCLES identical cycles trip it.
    always_comb begin
        hang_cnt_d = '0;
        if (in_run) begin
            if ((hang_cnt_q == '0) || (pc != last_pc_q)) begin
                hang_cnt_d = HANG_W'(1);
            end else begin
                hang_cnt_d = hang_cnt_q + HANG_W'(1);
            end
        end
    end

    always_comb begin
        hang_hit = in_run && (hang_cnt_d == HANG_W'(HANG_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc_q  <= '0;
            hang_cnt_q <= '0;
        end else begin
            last_pc_q  <= pc;
            hang_cnt_q <= hang_cnt_d;
        end
    end
`else
    localparam int unsigned unused_hang_cycles = HANG_CYCLES;
    logic unused_pc;

    assign unused_pc = ^pc;

    always_comb begin
        hang_hit = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start) state_d = StHold;
            StHold: if (hold_last) state_d = StRun;
            StRun:  if (tohost_hit || hang_hit || timeout_hit) state_d = StDone;
            StDone: if (start) state_d = StHold;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q        <= '0;
            cycle_count_q <= '0;
            fail_code_q   <= '0;
            pass_q        <= 1'b0;
            timeout_q     <= 1'b0;
            hang_q        <= 1'b0;
        end else begin
            hold_q <= (state_q == StHold) ? hold_q + HOLD_W'(1) : '0;
            if (start_ok) begin
                cycle_count_q <= '0;
                fail_code_q   <= '0;
                pass_q        <= 1'b0;
                timeout_q     <= 1'b0;
                hang_q        <= 1'b0;
            end else if (in_run) begin
                cycle_count_q <= count_inc;
                // Priority: tohost > hang > timeout; only the winner's flag is set.
                if (tohost_hit) begin
                    if (dmem_wdata == XLEN'(1)) begin
                        pass_q <= 1'b1;
                    end else begin
                        fail_code_q <= dmem_wdata >> 1;
                    end
                end else if (hang_hit) begin
                    hang_q <= 1'b1;
                end else if (timeout_hit) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        core_rst_n  = (state_q == StRun);
        running     = (state_q == StRun);
        done        = (state_q == StDone);
        pass        = pass_q;
        timeout     = timeout_q;
        hang        = hang_q;
        fail_code   = fail_code_q;
        cycle_count = cycle_count_q;
    end

endmodule
